// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the two-requester register-bank arbiter.
package reg_bank_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    // Round-robin pick: a lone requester wins; on a tie the one that did not win last goes.
    // Returns 0 for requester 0 and 1 for requester 1.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last_winner);
        if (req0 && req1) begin
            return ~last_winner;
        end
        return req1;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// DEPTH x DATA_W register storage: one write port, one registered read port, async clear.
module reg_bank
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and read-data capture; rdata only moves on a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small register bank.
// A transaction takes IDLE -> ACCESS -> ACK, so grants are spaced at least 3 cycles apart.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_e            state_q;
    logic              win_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              ack0_q;
    logic              ack1_q;

    logic              win_c;
    logic              bank_we_c;
    logic              bank_re_c;

    // Winner for a request sampled in IDLE.
    always_comb win_c = pick_winner(req0, req1, last_q);

    // Arbiter FSM; latches the winner's transaction and drives registered grant/ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= ST_ACCESS;
                        win_q   <= win_c;
                        we_q    <= win_c ? we1 : we0;
                        addr_q  <= win_c ? addr1 : addr0;
                        wdata_q <= win_c ? wdata1 : wdata0;
                        gnt0_q  <= ~win_c;
                        gnt1_q  <= win_c;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_ACK;
                    last_q  <= win_q;
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
            endcase
        end
    end

    // The bank is touched only in ACCESS, using the latched transaction.
    assign bank_we_c = (state_q == ST_ACCESS) && we_q;
    assign bank_re_c = (state_q == ST_ACCESS) && !we_q;

    reg_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bank_we_c),
        .re_i    (bank_re_c),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: hand-computed grant/ack/rdata sequences.
module tb_reg_bank_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, ack0, ack1, busy;
    logic [DW-1:0] rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata  (rdata),
        .busy   (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic g0, input logic g1,
                               input logic a0, input logic a1, input logic b,
                               input logic [DW-1:0] rd);
        check_eq({tag, ".gnt0"},  32'(gnt0),  32'(g0));
        check_eq({tag, ".gnt1"},  32'(gnt1),  32'(g1));
        check_eq({tag, ".ack0"},  32'(ack0),  32'(a0));
        check_eq({tag, ".ack1"},  32'(ack1),  32'(a1));
        check_eq({tag, ".busy"},  32'(busy),  32'(b));
        check_eq({tag, ".rdata"}, 32'(rdata), 32'(rd));
    endtask

    task automatic drive(input int who, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One isolated transaction from a single requester; rd_prev/rd_after are hand values.
    task automatic single(input string tag, input int who, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] rd_prev, input logic [DW-1:0] rd_after);
        logic g0, g1;
        g0 = (who == 0);
        g1 = (who == 1);
        drive(who, 1'b1, w, a, d);
        tick();
        expect_outs({tag, "@grant"}, g0, g1, 1'b0, 1'b0, 1'b1, rd_prev);
        tick();
        expect_outs({tag, "@ack"}, g0, g1, g0, g1, 1'b1, rd_after);
        drive(who, 1'b0, 1'b0, '0, '0);
        tick();
        expect_outs({tag, "@idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd_after);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge clk) begin
        check_eq("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
        check_eq("ack_mutex", 32'(ack0 & ack1), 32'd0);
        check_eq("busy_vs_gnt", 32'(busy), 32'(gnt0 | gnt1));
    end

    initial begin
        #1;
        expect_outs("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();

        // Write then read back from the other requester.
        single("wr0_a2", 0, 1'b1, 2'd2, 8'hA5, 8'h00, 8'h00);
        single("rd1_a2", 1, 1'b0, 2'd2, 8'h00, 8'h00, 8'hA5);

        // Tie after reset: requester 0 first, then alternation while both stay asserted.
        do_reset();
        drive(0, 1'b1, 1'b1, 2'd0, 8'h11);
        drive(1, 1'b1, 1'b1, 2'd1, 8'h22);
        for (int i = 0; i < 4; i++) begin
            logic w1;
            w1 = (i % 2 == 1);
            tick();
            expect_outs($sformatf("tie%0d@grant", i), ~w1, w1, 1'b0, 1'b0, 1'b1, 8'h00);
            tick();
            expect_outs($sformatf("tie%0d@ack", i), ~w1, w1, ~w1, w1, 1'b1, 8'h00);
            tick();
            expect_outs($sformatf("tie%0d@idle", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        single("rd1_a0", 1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h11);
        single("rd0_a1", 0, 1'b0, 2'd1, 8'h00, 8'h11, 8'h22);

        // Requester 1 held alone: served every 3 cycles, gnt0 never rises.
        drive(1, 1'b1, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_outs($sformatf("hold1_%0d@grant", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                        (i == 0) ? 8'h22 : 8'h11);
            tick();
            expect_outs($sformatf("hold1_%0d@ack", i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11);
            tick();
            expect_outs($sformatf("hold1_%0d@idle", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        end
        drive(1, 1'b0, 1'b0, '0, '0);

        // Request dropped right after grant, inputs scrambled: latched write still completes.
        drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
        tick();
        expect_outs("drop@grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        drive(0, 1'b0, 1'b0, 2'd0, 8'hEE);
        tick();
        expect_outs("drop@ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
        tick();
        expect_outs("drop@idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
        single("rd1_a1", 1, 1'b0, 2'd1, 8'h00, 8'h11, 8'h3C);
        single("rd1_a0b", 1, 1'b0, 2'd0, 8'h00, 8'h3C, 8'h11);

        // Reset during ACCESS of a write: immediate clear, no ack, entry reads back zero.
        single("wr0_a3", 0, 1'b1, 2'd3, 8'h5A, 8'h11, 8'h11);
        drive(0, 1'b1, 1'b1, 2'd3, 8'hFF);
        tick();
        expect_outs("abort@grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        rst = 1'b1;
        #1;
        expect_outs("abort@rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        expect_outs("abort@held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        tick();
        expect_outs("abort@after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        single("rd0_a1z", 0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h00);
        single("wr1_a0", 1, 1'b1, 2'd0, 8'h77, 8'h00, 8'h00);
        single("rd0_a3", 0, 1'b0, 2'd3, 8'h00, 8'h00, 8'h00);
        single("rd1_a0c", 1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
